// File: rtl/integer_divider_pkg.sv
// Shared definitions for the iterative integer divider: FSM encoding and default widths.
package integer_divider_pkg;

   localparam int unsigned DEFAULT_OPERAND_WIDTH = 64;
   localparam int unsigned DEFAULT_COUNTER_WIDTH = 7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/integer_divider_twos_complement_abs.sv
// Combinational magnitude of an optionally signed two's complement operand.
module twos_complement_abs #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             sign_i,
   input  logic [WIDTH-1:0] value_i,
   output logic [WIDTH-1:0] magnitude_o,
   output logic             is_negative_o
);

   // The most negative value maps onto itself, which is its correct unsigned magnitude.
   assign is_negative_o = sign_i & value_i[WIDTH-1];
   assign magnitude_o   = is_negative_o ? -value_i : value_i;

endmodule

// File: rtl/integer_divider.sv
// Restoring radix-2 divider: one quotient bit per cycle, valid/ack handshake on both sides.
module integer_divider
   import integer_divider_pkg::*;
#(
   parameter int unsigned OPERAND_WIDTH_IN_BITS = DEFAULT_OPERAND_WIDTH,
   parameter int unsigned COUNTER_WIDTH_IN_BITS = DEFAULT_COUNTER_WIDTH
) (
   input  logic                             clk_in,
   input  logic                             reset_in,
   input  logic                             dividend_valid_in,
   input  logic                             dividend_sign_in,
   input  logic [OPERAND_WIDTH_IN_BITS-1:0] dividend_in,
   input  logic                             divisor_valid_in,
   input  logic                             divisor_sign_in,
   input  logic [OPERAND_WIDTH_IN_BITS-1:0] divisor_in,
   output logic                             issue_ack_out,
   output logic                             quotient_valid_out,
   output logic                             quotient_sign_out,
   output logic [OPERAND_WIDTH_IN_BITS-1:0] quotient_out,
   output logic [OPERAND_WIDTH_IN_BITS-1:0] remainder_out,
   input  logic                             issue_ack_in,
   output logic                             divide_exception_out
);

   localparam int unsigned W = OPERAND_WIDTH_IN_BITS;
   localparam logic [COUNTER_WIDTH_IN_BITS-1:0] LAST_ITER = COUNTER_WIDTH_IN_BITS'(W - 1);

   div_state_e                 state_q, state_d;
   logic [COUNTER_WIDTH_IN_BITS-1:0] count_q, count_d;
   logic [W-1:0]               rem_q, rem_d;
   logic [W-1:0]               quo_q, quo_d;
   logic [W-1:0]               div_q, div_d;
   logic                       neg_quo_q, neg_quo_d;
   logic                       neg_rem_q, neg_rem_d;
   logic                       zero_q, zero_d;
   logic                       ack_q, ack_d;
   logic                       valid_q, valid_d;
   logic                       qsign_q, qsign_d;
   logic                       exc_q, exc_d;
   logic [W-1:0]               quot_out_q, quot_out_d;
   logic [W-1:0]               rem_out_q, rem_out_d;

   logic [W-1:0]               dvd_mag, dvs_mag;
   logic                       dvd_neg, dvs_neg;
   logic [W:0]                 shifted;
   logic [W:0]                 trial;

   twos_complement_abs #(.WIDTH(W)) u_dividend_abs (
      .sign_i        (dividend_sign_in),
      .value_i       (dividend_in),
      .magnitude_o   (dvd_mag),
      .is_negative_o (dvd_neg)
   );

   twos_complement_abs #(.WIDTH(W)) u_divisor_abs (
      .sign_i        (divisor_sign_in),
      .value_i       (divisor_in),
      .magnitude_o   (dvs_mag),
      .is_negative_o (dvs_neg)
   );

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         div_q      <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         zero_q     <= 1'b0;
         ack_q      <= 1'b0;
         valid_q    <= 1'b0;
         qsign_q    <= 1'b0;
         exc_q      <= 1'b0;
         quot_out_q <= '0;
         rem_out_q  <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         div_q      <= div_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         zero_q     <= zero_d;
         ack_q      <= ack_d;
         valid_q    <= valid_d;
         qsign_q    <= qsign_d;
         exc_q      <= exc_d;
         quot_out_q <= quot_out_d;
         rem_out_q  <= rem_out_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      div_d      = div_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      zero_d     = zero_q;
      ack_d      = 1'b0;
      valid_d    = valid_q;
      qsign_d    = qsign_q;
      exc_d      = exc_q;
      quot_out_d = quot_out_q;
      rem_out_d  = rem_out_q;
      // Partial remainder is always below the divisor, so W+1 bits hold the trial sign.
      shifted    = {rem_q, quo_q[W-1]};
      trial      = shifted - {1'b0, div_q};

      unique case (state_q)
         S_IDLE: begin
            if (dividend_valid_in && divisor_valid_in) begin
               ack_d     = 1'b1;
               count_d   = '0;
               rem_d     = '0;
               div_d     = dvs_mag;
               neg_quo_d = dvd_neg ^ dvs_neg;
               neg_rem_d = dvd_neg;
               zero_d    = (divisor_in == '0);
               if (divisor_in == '0) begin
                  // Raw dividend parks in the quotient register for the exception remainder.
                  quo_d   = dividend_in;
                  state_d = S_FIX;
               end else begin
                  quo_d   = dvd_mag;
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            if (!trial[W]) begin
               rem_d = trial[W-1:0];
               quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
               rem_d = shifted[W-1:0];
               quo_d = {quo_q[W-2:0], 1'b0};
            end
            count_d = count_q + 1'b1;
            if (count_q == LAST_ITER) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            valid_d = 1'b1;
            state_d = S_DONE;
            if (zero_q) begin
               quot_out_d = '1;
               rem_out_d  = quo_q;
               exc_d      = 1'b1;
               qsign_d    = 1'b0;
            end else begin
               quot_out_d = neg_quo_q ? -quo_q : quo_q;
               rem_out_d  = neg_rem_q ? -rem_q : rem_q;
               exc_d      = 1'b0;
               qsign_d    = neg_quo_q & (quo_q != '0);
            end
         end
         S_DONE: begin
            if (issue_ack_in) begin
               valid_d    = 1'b0;
               exc_d      = 1'b0;
               qsign_d    = 1'b0;
               quot_out_d = '0;
               rem_out_d  = '0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign issue_ack_out        = ack_q;
   assign quotient_valid_out   = valid_q;
   assign quotient_sign_out    = qsign_q;
   assign quotient_out         = quot_out_q;
   assign remainder_out        = rem_out_q;
   assign divide_exception_out = exc_q;

endmodule

// File: tb/tb_integer_divider.sv
// Scoreboard bench for integer_divider: driver pushes expected results, monitor pops on valid.
module tb_integer_divider;

   localparam int unsigned W = 64;

   logic          clk_in = 1'b0;
   logic          reset_in = 1'b1;
   logic          dividend_valid_in = 1'b0;
   logic          dividend_sign_in = 1'b0;
   logic [W-1:0]  dividend_in = '0;
   logic          divisor_valid_in = 1'b0;
   logic          divisor_sign_in = 1'b0;
   logic [W-1:0]  divisor_in = '0;
   logic          issue_ack_out;
   logic          quotient_valid_out;
   logic          quotient_sign_out;
   logic [W-1:0]  quotient_out;
   logic [W-1:0]  remainder_out;
   logic          issue_ack_in = 1'b0;
   logic          divide_exception_out;

   integer_divider #(
      .OPERAND_WIDTH_IN_BITS (64),
      .COUNTER_WIDTH_IN_BITS (7)
   ) dut (
      .clk_in               (clk_in),
      .reset_in             (reset_in),
      .dividend_valid_in    (dividend_valid_in),
      .dividend_sign_in     (dividend_sign_in),
      .dividend_in          (dividend_in),
      .divisor_valid_in     (divisor_valid_in),
      .divisor_sign_in      (divisor_sign_in),
      .divisor_in           (divisor_in),
      .issue_ack_out        (issue_ack_out),
      .quotient_valid_out   (quotient_valid_out),
      .quotient_sign_out    (quotient_sign_out),
      .quotient_out         (quotient_out),
      .remainder_out        (remainder_out),
      .issue_ack_in         (issue_ack_in),
      .divide_exception_out (divide_exception_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      string        name;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         s;
      logic         e;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   ack_cyc  = 0;
   logic prev_valid = 1'b0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
   endtask

   // Monitor: compares against the oldest expectation whenever a result is first presented.
   always @(negedge clk_in) begin
      exp_t e;
      cyc++;
      if (issue_ack_out) ack_cyc = cyc;
      if (quotient_valid_out && !prev_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check({e.name, "_quotient"},  quotient_out, e.q);
            check({e.name, "_remainder"}, remainder_out, e.r);
            check({e.name, "_sign"},      {63'd0, quotient_sign_out}, {63'd0, e.s});
            check({e.name, "_exception"}, {63'd0, divide_exception_out}, {63'd0, e.e});
            check({e.name, "_latency"},   64'(cyc - ack_cyc), 64'(e.lat));
         end
      end
      prev_valid = quotient_valid_out;
   end

   task automatic push_exp(input string name, input logic [W-1:0] q, input logic [W-1:0] r,
                           input logic s, input logic e, input int lat);
      exp_t x;
      x.name = name; x.q = q; x.r = r; x.s = s; x.e = e; x.lat = lat;
      sb.push_back(x);
   endtask

   task automatic issue(input logic [W-1:0] dvd, input logic ds, input logic [W-1:0] dvs,
                        input logic vs);
      int i;
      dividend_in = dvd; dividend_sign_in = ds; dividend_valid_in = 1'b1;
      divisor_in  = dvs; divisor_sign_in  = vs; divisor_valid_in  = 1'b1;
      i = 0;
      do begin
         @(negedge clk_in);
         i++;
      end while (!issue_ack_out && i < 10);
      check("issue_ack_seen", {63'd0, issue_ack_out}, 64'd1);
      dividend_valid_in = 1'b0;
      divisor_valid_in  = 1'b0;
      @(negedge clk_in);
      check("issue_ack_pulse", {63'd0, issue_ack_out}, 64'd0);
   endtask

   task automatic wait_result();
      for (int i = 0; i < 100 && !quotient_valid_out; i++) @(negedge clk_in);
      check("result_valid_seen", {63'd0, quotient_valid_out}, 64'd1);
   endtask

   task automatic ack_result();
      issue_ack_in = 1'b1;
      @(negedge clk_in);
      issue_ack_in = 1'b0;
      check("clear_valid", {63'd0, quotient_valid_out}, 64'd0);
      check("clear_quotient", quotient_out, 64'd0);
      check("clear_exception", {63'd0, divide_exception_out}, 64'd0);
   endtask

   task automatic run_op(input string name, input logic [W-1:0] dvd, input logic ds,
                         input logic [W-1:0] dvs, input logic vs, input logic [W-1:0] q,
                         input logic [W-1:0] r, input logic s, input logic e, input int lat);
      push_exp(name, q, r, s, e, lat);
      issue(dvd, ds, dvs, vs);
      wait_result();
      ack_result();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] q0, r0;
      logic [2:0]   f0;
      logic         stable, seen;
      int           edges;

      repeat (3) @(negedge clk_in);
      check("reset_flags", {60'd0, issue_ack_out, quotient_valid_out, quotient_sign_out,
                            divide_exception_out}, 64'd0);
      check("reset_quotient", quotient_out, 64'd0);
      check("reset_remainder", remainder_out, 64'd0);
      reset_in = 1'b0;
      @(negedge clk_in);

      // A single valid operand must never be accepted.
      seen = 1'b0;
      dividend_in = 64'd9; divisor_in = 64'd3;
      dividend_valid_in = 1'b1;
      repeat (5) begin @(negedge clk_in); if (issue_ack_out) seen = 1'b1; end
      dividend_valid_in = 1'b0; divisor_valid_in = 1'b1;
      repeat (5) begin @(negedge clk_in); if (issue_ack_out) seen = 1'b1; end
      divisor_valid_in = 1'b0;
      check("one_valid_no_ack", {63'd0, seen}, 64'd0);

      run_op("u100_7", 64'd100, 1'b0, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 1'b0, 65);
      run_op("sm100_7", 64'hFFFF_FFFF_FFFF_FF9C, 1'b1, 64'd7, 1'b1,
             64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 65);
      run_op("s100_m7", 64'd100, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1,
             64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b1, 1'b0, 65);
      run_op("sm3_7", 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 64'd7, 1'b1,
             64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 65);
      run_op("u5_0", 64'd5, 1'b0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b0, 1'b1, 1);
      run_op("sm7_0", 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 64'd0, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b1, 1);
      run_op("smin_m1", 64'h8000_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
             64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b0, 65);
      run_op("umax_2", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd2, 1'b0,
             64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 65);
      run_op("umax_maxm1", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0,
             64'd1, 64'd1, 1'b0, 1'b0, 65);

      // Back-pressure: result held, new operands waiting, nothing accepted until consumer ack.
      push_exp("bp_first", 64'd100, 64'd0, 1'b0, 1'b0, 65);
      issue(64'd1000, 1'b0, 64'd10, 1'b0);
      wait_result();
      q0 = quotient_out; r0 = remainder_out;
      f0 = {quotient_valid_out, quotient_sign_out, divide_exception_out};
      push_exp("bp_next", 64'd3, 64'd0, 1'b0, 1'b0, 65);
      dividend_in = 64'd9; divisor_in = 64'd3;
      dividend_sign_in = 1'b0; divisor_sign_in = 1'b0;
      dividend_valid_in = 1'b1; divisor_valid_in = 1'b1;
      stable = 1'b1; seen = 1'b0;
      repeat (20) begin
         @(negedge clk_in);
         if (quotient_out !== q0 || remainder_out !== r0 ||
             {quotient_valid_out, quotient_sign_out, divide_exception_out} !== f0) stable = 1'b0;
         if (issue_ack_out) seen = 1'b1;
      end
      check("bp_outputs_stable", {63'd0, stable}, 64'd1);
      check("bp_no_issue_ack", {63'd0, seen}, 64'd0);
      issue_ack_in = 1'b1;
      @(negedge clk_in);
      edges = 1;
      issue_ack_in = 1'b0;
      check("bp_cleared_valid", {63'd0, quotient_valid_out}, 64'd0);
      while (!issue_ack_out && edges < 8) begin
         @(negedge clk_in);
         edges++;
      end
      check("bp_reaccept_edges", 64'(edges), 64'd2);
      dividend_valid_in = 1'b0; divisor_valid_in = 1'b0;
      wait_result();
      ack_result();

      // Reset mid-BUSY discards the in-flight divide.
      issue(64'd12345, 1'b0, 64'd3, 1'b0);
      repeat (28) @(negedge clk_in);
      reset_in = 1'b1;
      @(negedge clk_in);
      check("midrst_flags", {60'd0, issue_ack_out, quotient_valid_out, quotient_sign_out,
                             divide_exception_out}, 64'd0);
      check("midrst_quotient", quotient_out, 64'd0);
      check("midrst_remainder", remainder_out, 64'd0);
      reset_in = 1'b0;
      @(negedge clk_in);
      run_op("u64_8", 64'd64, 1'b0, 64'd8, 1'b0, 64'd8, 64'd0, 1'b0, 1'b0, 65);

      repeat (5) @(negedge clk_in);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
